// File: rtl/clk_rst_pkg.sv
// ---------------------------------------------------------------------------
// clk_rst_pkg
// Shared definitions for the core-domain reset sequencer: the FSM state
// encoding (also exported on the debug/CSR state port), the width of that
// state field, and a small helper used to size the cycle counter.
// ---------------------------------------------------------------------------
package clk_rst_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_rst_seq_sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// Multi-flop synchroniser for a single asynchronous level into the i_clk
// domain. All flops reset to 0, so until the chain has filled after reset
// the output reads as "not locked" / "external reset active".
// Ports:
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset, forces the chain to 0
//   i_d      asynchronous input level
//   o_q      synchronised level, STAGES clocks behind i_d
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the chain; only the last flop is used.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = chain[STAGES-1];

endmodule

// File: rtl/clk_rst_seq.sv
// ---------------------------------------------------------------------------
// clk_rst_seq
// Reset sequencer for the core clock domain, placed directly after the PLL.
// Waits for PLL lock to be continuously stable, then releases N_RST reset
// domains one after another (bit 0 first). Any reset source (lock loss,
// push-button, software request) drops every domain together on the next
// edge and restarts the whole sequence. Loss of lock after the first
// release is recorded in a sticky flag.
// Ports:
//   i_clk         core clock (PLL output)
//   i_rst_n       asynchronous active-low reset of this block
//   i_pll_locked  PLL lock, asynchronous
//   i_ext_rst_n   push-button reset, active-low, asynchronous
//   i_sw_rst_req  single-cycle software reset request (i_clk domain)
//   i_clr_flags   clears o_lock_lost (i_clk domain)
//   o_rst_n       sequenced active-low domain resets, bit 0 released first
//   o_ready       high while every domain is released (state RUN)
//   o_lock_lost   sticky: lock dropped while releasing or running
//   o_state       current FSM state for debug/CSR
// ---------------------------------------------------------------------------
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int N_RST       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pll_locked,
    input  logic               i_ext_rst_n,
    input  logic               i_sw_rst_req,
    input  logic               i_clr_flags,
    output logic [N_RST-1:0]   o_rst_n,
    output logic               o_ready,
    output logic               o_lock_lost,
    output logic [STATE_W-1:0] o_state
);

    localparam int CNT_MAX = max_int(HOLD_CYCLES, STAGE_GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    logic             lock_s;
    logic             ext_n_s;
    logic             abort;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N_RST-1:0] rst_q;
    logic [N_RST-1:0] rst_next;
    logic             ready_q;
    logic             lost_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_lock (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_pll_locked),
        .o_q     (lock_s)
    );

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_ext (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_ext_rst_n),
        .o_q     (ext_n_s)
    );

    assign abort = !lock_s || !ext_n_s || i_sw_rst_req;

    // The released domains form a thermometer code growing from bit 0, so
    // the next release pattern is a shift-in of a 1; it also serves as the
    // stage index (all ones means the last domain has just been released).
    assign rst_next = (rst_q << 1) | N_RST'(1);

    // Sequencer FSM. Every abort lands in WAIT_LOCK with all domains held
    // and counters cleared in the same edge, so there is never a partially
    // released state after a reset source fires. The hold count restarts
    // from zero whenever lock blinks, enforcing a continuous-lock window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    cnt     <= '0;
                    rst_q   <= '0;
                    ready_q <= 1'b0;
                    if (!abort) begin
                        state <= HOLD;
                    end
                end
                HOLD, RELEASE: begin
                    if (abort) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        rst_q   <= '0;
                        ready_q <= 1'b0;
                    end else if ((state == HOLD && cnt == HOLD_LAST) ||
                                 (state == RELEASE && cnt == GAP_LAST)) begin
                        rst_q <= rst_next;
                        cnt   <= '0;
                        if (&rst_next) begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        rst_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= WAIT_LOCK;
                    cnt     <= '0;
                    rst_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky lock-lost flag. Only counts once something has been released;
    // losing lock during the initial hold is normal PLL settling. A set in
    // the same cycle as a software clear takes priority so no event is lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lost_q <= 1'b0;
        end else if (!lock_s && (state == RELEASE || state == RUN)) begin
            lost_q <= 1'b1;
        end else if (i_clr_flags) begin
            lost_q <= 1'b0;
        end
    end

    assign o_rst_n     = rst_q;
    assign o_ready     = ready_q;
    assign o_lock_lost = lost_q;
    assign o_state     = state;

endmodule

// File: tb/tb_clk_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_clk_rst_seq
// Testbench for the reset sequencer. The stimulus process queues the output
// transitions it expects (edge number and output values); a monitor watching
// the outputs pops one entry per observed change and compares. A second
// instance with a single reset domain shares the inputs and is checked
// directly at its release edge.
// ---------------------------------------------------------------------------
module tb_clk_rst_seq;
    import clk_rst_pkg::*;

    typedef struct packed {
        logic [31:0] edge_no;
        logic [2:0]  rst;
        logic        ready;
        logic        lost;
        logic [1:0]  state;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pll_locked;
    logic        ext_rst_n;
    logic        sw_rst_req;
    logic        clr_flags;

    logic [2:0]  rst0_n;
    logic        ready0;
    logic        lost0;
    logic [1:0]  state0;

    logic [0:0]  rst1_n;
    logic        ready1;
    logic        lost1;
    logic [1:0]  state1;

    int unsigned edge_cnt = 0;
    int          checks   = 0;
    int          errors   = 0;

    exp_t        exp_q[$];
    string       name_q[$];
    logic [4:0]  prev_out = 5'b0;
    logic [4:0]  cur_out;

    int unsigned base;
    int unsigned base2;

    clk_rst_seq #(
        .N_RST       (3),
        .SYNC_STAGES (2),
        .HOLD_CYCLES (16),
        .STAGE_GAP   (8)
    ) u_dut0 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pll_locked (pll_locked),
        .i_ext_rst_n  (ext_rst_n),
        .i_sw_rst_req (sw_rst_req),
        .i_clr_flags  (clr_flags),
        .o_rst_n      (rst0_n),
        .o_ready      (ready0),
        .o_lock_lost  (lost0),
        .o_state      (state0)
    );

    clk_rst_seq #(
        .N_RST       (1),
        .SYNC_STAGES (2),
        .HOLD_CYCLES (16),
        .STAGE_GAP   (8)
    ) u_dut1 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pll_locked (pll_locked),
        .i_ext_rst_n  (ext_rst_n),
        .i_sw_rst_req (sw_rst_req),
        .i_clr_flags  (clr_flags),
        .o_rst_n      (rst1_n),
        .o_ready      (ready1),
        .o_lock_lost  (lost1),
        .o_state      (state1)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Edge counter used to time-stamp both stimulus and observed outputs.
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
    end

    task automatic applyStimulus(input logic lock, input logic ext_n,
                                 input logic sw, input logic clr);
        pll_locked = lock;
        ext_rst_n  = ext_n;
        sw_rst_req = sw;
        clr_flags  = clr;
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] act,
                               input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic pushExpect(input int unsigned e, input logic [2:0] r,
                              input logic rdy, input logic lst,
                              input logic [1:0] st, input string nm);
        exp_t item;
        item.edge_no = e;
        item.rst     = r;
        item.ready   = rdy;
        item.lost    = lst;
        item.state   = st;
        exp_q.push_back(item);
        name_q.push_back(nm);
    endtask

    // Advance to 1 ns after the requested edge.
    task automatic wait_edge(input int unsigned n);
        while (edge_cnt < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every change of the domain outputs is one observed event,
    // compared against the oldest queued expectation.
    always @(negedge clk) begin
        cur_out = {rst0_n, ready0, lost0};
        if (cur_out !== prev_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_change: edge=%0d rst=%b rdy=%b lost=%b st=%0d, expected no change",
                         edge_cnt, rst0_n, ready0, lost0, state0);
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (edge_cnt != e.edge_no || rst0_n !== e.rst || ready0 !== e.ready ||
                    lost0 !== e.lost || state0 !== e.state) begin
                    errors++;
                    $display("[TB] FAIL %s: got edge=%0d rst=%b rdy=%b lost=%b st=%0d, expected edge=%0d rst=%b rdy=%b lost=%b st=%0d",
                             nm, edge_cnt, rst0_n, ready0, lost0, state0,
                             e.edge_no, e.rst, e.ready, e.lost, e.state);
                end
            end
            prev_out = cur_out;
        end
    end

    // Directed scenarios run back to back; each queues its expected
    // transitions up front.
    initial begin
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("reset_dut0", {24'd0, rst0_n, ready0, lost0, state0}, 32'd0);
        checkOutput("reset_dut1", {26'd0, rst1_n, ready1, lost1, state1}, 32'd0);
        rst_n = 1'b1;

        // Power-up release sequence.
        @(posedge clk);
        #1;
        base = edge_cnt;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        pushExpect(base + 19, 3'b001, 1'b0, 1'b0, RELEASE, "pwr_rel0");
        pushExpect(base + 27, 3'b011, 1'b0, 1'b0, RELEASE, "pwr_rel1");
        pushExpect(base + 35, 3'b111, 1'b1, 1'b0, RUN,     "pwr_run");
        wait_edge(base + 18);
        checkOutput("n1_before_rel", {30'd0, rst1_n, ready1}, 32'd0);
        wait_edge(base + 19);
        checkOutput("n1_rel_ready", {28'd0, rst1_n, ready1, state1}, {28'd0, 1'b1, 1'b1, RUN});
        wait_edge(base + 40);

        // Lock blink in RUN with a flag clear pending: set must win.
        base = edge_cnt;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        pushExpect(base + 3,  3'b000, 1'b0, 1'b1, WAIT_LOCK, "lock_drop");
        pushExpect(base + 20, 3'b001, 1'b0, 1'b1, RELEASE,   "relock_rel0");
        pushExpect(base + 28, 3'b011, 1'b0, 1'b1, RELEASE,   "relock_rel1");
        pushExpect(base + 36, 3'b111, 1'b1, 1'b1, RUN,       "relock_run");
        pushExpect(base + 46, 3'b111, 1'b1, 1'b0, RUN,       "flag_clear");
        wait_edge(base + 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        wait_edge(base + 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        wait_edge(base + 45);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        wait_edge(base + 46);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        wait_edge(base + 50);

        // Software reset request from RUN.
        base = edge_cnt;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        pushExpect(base + 1,  3'b000, 1'b0, 1'b0, WAIT_LOCK, "sw_assert");
        pushExpect(base + 18, 3'b001, 1'b0, 1'b0, RELEASE,   "sw_rel0");
        pushExpect(base + 26, 3'b011, 1'b0, 1'b0, RELEASE,   "sw_rel1");
        wait_edge(base + 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

        // Push-button reset while only two domains are out.
        wait_edge(base + 28);
        base = edge_cnt;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        pushExpect(base + 3, 3'b000, 1'b0, 1'b0, WAIT_LOCK, "ext_assert");
        wait_edge(base + 20);
        base2 = edge_cnt;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        pushExpect(base2 + 19, 3'b001, 1'b0, 1'b0, RELEASE, "ext_rel0");
        pushExpect(base2 + 27, 3'b011, 1'b0, 1'b0, RELEASE, "ext_rel1");
        pushExpect(base2 + 35, 3'b111, 1'b1, 1'b0, RUN,     "ext_run");
        wait_edge(base2 + 40);

        // Asynchronous block reset in the middle of a cycle.
        #2;
        pushExpect(edge_cnt, 3'b000, 1'b0, 1'b0, WAIT_LOCK, "async_evt");
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("async_dut0", {24'd0, rst0_n, ready0, lost0, state0}, 32'd0);
        checkOutput("async_dut1", {26'd0, rst1_n, ready1, lost1, state1}, 32'd0);
        wait_edge(edge_cnt + 3);
        rst_n = 1'b1;

        // Lock glitch during HOLD restarts the hold window.
        wait_edge(edge_cnt + 2);
        base = edge_cnt;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        pushExpect(base + 30, 3'b001, 1'b0, 1'b0, RELEASE, "glitch_rel0");
        pushExpect(base + 38, 3'b011, 1'b0, 1'b0, RELEASE, "glitch_rel1");
        pushExpect(base + 46, 3'b111, 1'b1, 1'b0, RUN,     "glitch_run");
        wait_edge(base + 10);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        wait_edge(base + 11);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        wait_edge(base + 50);

        while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no output change, expected change at edge %0d", nm, e.edge_no);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
